character_action_controller: RTL and testbench

//   Per-player action sequencer driving the 64x240 sprite/hitbox renderer.

---
 rtl/char_pkg.sv | 25 ++
 rtl/character_action_controller_if.sv | 24 ++
 rtl/action_input_latch.sv | 45 ++++
 rtl/character_action_controller.sv | 150 +++++++++++++++
 tb/tb_character_action_controller.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/char_pkg.sv
// Shared types and screen geometry for the per-player character action controller.
// Attack and hit-stun phase lengths are clamped to a minimum of one frame by phase_last().
package char_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WALK_L   = 3'd1,
    ST_WALK_R   = 3'd2,
    ST_HITSTUN  = 3'd3,
    ST_STARTUP  = 3'd4,
    ST_ACTIVE   = 3'd5,
    ST_RECOVERY = 3'd6
  } state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 64;
  localparam int SPRITE_H = 240;

  // Last 0-based frame index of a timed phase; a zero length behaves as one frame.
  function automatic logic [3:0] phase_last(input logic [3:0] len);
    return (len == 4'd0) ? 4'd0 : (len - 4'd1);
  endfunction

endpackage

// File: rtl/character_action_controller_if.sv
// Player input / renderer output bundle for character_action_controller.
// master drives the per-frame inputs, slave is the controller itself.
interface character_action_controller_if;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_attack;
  logic       hit_in;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] state;
  logic       attacking;
  logic [3:0] phase_frame;

  modport master (
    output frame_tick, btn_left, btn_right, btn_attack, hit_in,
    input  x_pos, y_pos, state, attacking, phase_frame
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, btn_attack, hit_in,
    output x_pos, y_pos, state, attacking, phase_frame
  );
endinterface

// File: rtl/action_input_latch.sv
// Rising-edge capture of btn_attack and hit_in into latches that every frame tick clears.
// The pending outputs include an edge arriving on the tick clock itself so it is not lost.
module action_input_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic btn_attack,
  input  logic hit_in,
  output logic attack_pend,
  output logic hit_pend
);

  logic atk_prev_r;
  logic hit_prev_r;
  logic atk_latch_r;
  logic hit_latch_r;
  logic atk_edge_s;
  logic hit_edge_s;

  assign atk_edge_s  = btn_attack & ~atk_prev_r;
  assign hit_edge_s  = hit_in & ~hit_prev_r;
  assign attack_pend = atk_latch_r | atk_edge_s;
  assign hit_pend    = hit_latch_r | hit_edge_s;

  // Edge history and set-on-edge / clear-on-tick latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      atk_prev_r  <= 1'b0;
      hit_prev_r  <= 1'b0;
      atk_latch_r <= 1'b0;
      hit_latch_r <= 1'b0;
    end else begin
      atk_prev_r <= btn_attack;
      hit_prev_r <= hit_in;
      if (frame_tick) begin
        atk_latch_r <= 1'b0;
        hit_latch_r <= 1'b0;
      end else begin
        atk_latch_r <= attack_pend;
        hit_latch_r <= hit_pend;
      end
    end
  end

endmodule

// File: rtl/character_action_controller.sv
// Per-player action sequencer: per-frame walk with edge clamping and timed attack phases.
// Optional feature macro: HITSTUN_EN (latched hit_in forces a timed HITSTUN phase).
module character_action_controller
  import char_pkg::*;
#(
  parameter logic [9:0] X_INIT      = 10'd100,
  parameter logic [9:0] Y_FIXED     = 10'((SCREEN_H - SPRITE_H) / 2),
  parameter logic [9:0] X_MIN       = 10'd0,
  parameter logic [9:0] X_MAX       = 10'(SCREEN_W - SPRITE_W),
  parameter logic [9:0] MOVE_STEP   = 10'd3,
  parameter logic [3:0] STARTUP_FR  = 4'd5,
  parameter logic [3:0] ACTIVE_FR   = 4'd2,
  parameter logic [3:0] RECOVERY_FR = 4'd8,
  parameter logic [3:0] HITSTUN_FR  = 4'd12
) (
  input logic                          clk,
  input logic                          rst_n,
  character_action_controller_if.slave bus
);

  state_e     state_r;
  state_e     state_nx_s;
  logic [9:0] x_r;
  logic [9:0] x_nx_s;
  logic [3:0] phase_r;
  logic [3:0] phase_nx_s;
  logic       attacking_r;
  logic       attacking_nx_s;
  logic       attack_pend_s;
  logic       hit_pend_s;
  logic       hit_s;
  logic [10:0] x_sum_s;
  logic [9:0]  x_left_s;
  logic [9:0]  x_right_s;

  action_input_latch u_latch (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (bus.frame_tick),
    .btn_attack  (bus.btn_attack),
    .hit_in      (bus.hit_in),
    .attack_pend (attack_pend_s),
    .hit_pend    (hit_pend_s)
  );

`ifdef HITSTUN_EN
  assign hit_s = hit_pend_s;
`else
  logic unused_hit_s;
  assign unused_hit_s = hit_pend_s;
  assign hit_s        = 1'b0;
`endif

  // Saturating walk targets, evaluated in 11 bits so neither direction can wrap.
  always_comb begin
    x_sum_s = {1'b0, x_r} + {1'b0, MOVE_STEP};
    if ({1'b0, x_r} < ({1'b0, X_MIN} + {1'b0, MOVE_STEP})) begin
      x_left_s = X_MIN;
    end else begin
      x_left_s = x_r - MOVE_STEP;
    end
    if (x_sum_s > {1'b0, X_MAX}) begin
      x_right_s = X_MAX;
    end else begin
      x_right_s = x_sum_s[9:0];
    end
  end

  // Next-state, position and phase counter; everything holds between frame ticks.
  always_comb begin
    state_nx_s = state_r;
    x_nx_s     = x_r;
    phase_nx_s = phase_r;
    if (!bus.frame_tick) begin
      state_nx_s = state_r;
    end else if (hit_s && (state_r != ST_HITSTUN)) begin
      state_nx_s = ST_HITSTUN;
      phase_nx_s = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_WALK_L, ST_WALK_R: begin
          phase_nx_s = 4'd0;
          if (attack_pend_s) begin
            state_nx_s = ST_STARTUP;
          end else if (bus.btn_left && !bus.btn_right) begin
            state_nx_s = ST_WALK_L;
            x_nx_s     = x_left_s;
          end else if (bus.btn_right && !bus.btn_left) begin
            state_nx_s = ST_WALK_R;
            x_nx_s     = x_right_s;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_STARTUP: begin
          if (phase_r >= phase_last(STARTUP_FR)) begin
            state_nx_s = ST_ACTIVE;
            phase_nx_s = 4'd0;
          end else begin
            phase_nx_s = phase_r + 4'd1;
          end
        end
        ST_ACTIVE: begin
          if (phase_r >= phase_last(ACTIVE_FR)) begin
            state_nx_s = ST_RECOVERY;
            phase_nx_s = 4'd0;
          end else begin
            phase_nx_s = phase_r + 4'd1;
          end
        end
        ST_RECOVERY, ST_HITSTUN: begin
          if (phase_r >= phase_last((state_r == ST_HITSTUN) ? HITSTUN_FR : RECOVERY_FR)) begin
            state_nx_s = ST_IDLE;
            phase_nx_s = 4'd0;
          end else begin
            phase_nx_s = phase_r + 4'd1;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          phase_nx_s = 4'd0;
        end
      endcase
    end
    attacking_nx_s = (state_nx_s == ST_STARTUP) || (state_nx_s == ST_ACTIVE) ||
                     (state_nx_s == ST_RECOVERY);
  end

  // Registered FSM state and renderer-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      x_r         <= X_INIT;
      phase_r     <= 4'd0;
      attacking_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      x_r         <= x_nx_s;
      phase_r     <= phase_nx_s;
      attacking_r <= attacking_nx_s;
    end
  end

  assign bus.x_pos       = x_r;
  assign bus.y_pos       = Y_FIXED;
  assign bus.state       = state_r;
  assign bus.attacking   = attacking_r;
  assign bus.phase_frame = phase_r;

endmodule

// File: tb/tb_character_action_controller.sv
// Directed, table-driven bench for character_action_controller (default and HITSTUN_EN builds).
module tb_character_action_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #20 clk = ~clk;

  character_action_controller_if bus ();

  character_action_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       left;
    logic       right;
    logic       atk;
    logic [2:0] st;
    logic [9:0] x;
    logic       att;
    logic [3:0] ph;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] st, input logic [9:0] x,
                           input logic att, input logic [3:0] ph);
    chk({tag, ".state"}, {13'd0, bus.state}, {13'd0, st});
    chk({tag, ".x_pos"}, {6'd0, bus.x_pos}, {6'd0, x});
    chk({tag, ".attacking"}, {15'd0, bus.attacking}, {15'd0, att});
    chk({tag, ".phase"}, {12'd0, bus.phase_frame}, {12'd0, ph});
  endtask

  task automatic add(input logic l, input logic r, input logic a, input logic [2:0] st,
                     input logic [9:0] x, input logic att, input logic [3:0] ph);
    vec_t v;
    v.left = l; v.right = r; v.atk = a; v.st = st; v.x = x; v.att = att; v.ph = ph;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
  endtask

  task automatic pulse_attack();
    @(negedge clk) bus.btn_attack = 1'b1;
    @(negedge clk) bus.btn_attack = 1'b0;
  endtask

  task automatic pulse_hit();
    @(negedge clk) bus.hit_in = 1'b1;
    @(negedge clk) bus.hit_in = 1'b0;
  endtask

  task automatic do_reset();
    bus.frame_tick = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    bus.btn_attack = 1'b0; bus.hit_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    check_out("reset", 3'd0, 10'd100, 1'b0, 4'd0);
    chk("reset.y_pos", {6'd0, bus.y_pos}, 16'd120);

    // Idle, walk right, release, attack with left held, then walk left.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 3'd0, 10'd100, 1'b0, 4'd0);
    for (int i = 1; i <= 4; i++) add(1'b0, 1'b1, 1'b0, 3'd2, 10'(100 + 3 * i), 1'b0, 4'd0);
    add(1'b0, 1'b0, 1'b0, 3'd0, 10'd112, 1'b0, 4'd0);
    for (int p = 0; p < 5; p++) add(1'b1, 1'b0, p == 0, 3'd4, 10'd112, 1'b1, 4'(p));
    for (int p = 0; p < 2; p++) add(1'b1, 1'b0, 1'b0, 3'd5, 10'd112, 1'b1, 4'(p));
    for (int p = 0; p < 8; p++) add(1'b1, 1'b0, 1'b0, 3'd6, 10'd112, 1'b1, 4'(p));
    add(1'b1, 1'b0, 1'b0, 3'd0, 10'd112, 1'b0, 4'd0);
    add(1'b1, 1'b0, 1'b0, 3'd1, 10'd109, 1'b0, 4'd0);
    add(1'b0, 1'b0, 1'b0, 3'd0, 10'd109, 1'b0, 4'd0);
    // Attack presses during ACTIVE and on the last RECOVERY frame are dropped.
    for (int p = 0; p < 5; p++) add(1'b0, 1'b0, p == 0, 3'd4, 10'd109, 1'b1, 4'(p));
    add(1'b0, 1'b0, 1'b0, 3'd5, 10'd109, 1'b1, 4'd0);
    add(1'b0, 1'b0, 1'b1, 3'd5, 10'd109, 1'b1, 4'd1);
    for (int p = 0; p < 8; p++) add(1'b0, 1'b0, p == 7, 3'd6, 10'd109, 1'b1, 4'(p));
    add(1'b0, 1'b0, 1'b0, 3'd0, 10'd109, 1'b0, 4'd0);
    add(1'b0, 1'b0, 1'b0, 3'd0, 10'd109, 1'b0, 4'd0);
    add(1'b1, 1'b1, 1'b0, 3'd0, 10'd109, 1'b0, 4'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.btn_left  = vecs[i].left;
      bus.btn_right = vecs[i].right;
      if (vecs[i].atk) pulse_attack();
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].x, vecs[i].att, vecs[i].ph);
    end
    bus.btn_left = 1'b0; bus.btn_right = 1'b0;

    // Left edge clamp: 33 steps reach x=1, then saturate at 0.
    do_reset();
    bus.btn_left = 1'b1;
    repeat (33) tick();
    check_out("left_x1", 3'd1, 10'd1, 1'b0, 4'd0);
    tick();
    check_out("left_clamp0", 3'd1, 10'd0, 1'b0, 4'd0);
    tick();
    check_out("left_hold0", 3'd1, 10'd0, 1'b0, 4'd0);
    bus.btn_left = 1'b0;

    // Right edge clamp: 158 steps reach x=574, then saturate at 576.
    do_reset();
    bus.btn_right = 1'b1;
    repeat (158) tick();
    check_out("right_x574", 3'd2, 10'd574, 1'b0, 4'd0);
    tick();
    check_out("right_clamp576", 3'd2, 10'd576, 1'b0, 4'd0);
    tick();
    check_out("right_hold576", 3'd2, 10'd576, 1'b0, 4'd0);
    bus.btn_right = 1'b0;

    // No change between ticks.
    repeat (5) @(negedge clk);
    check_out("no_tick_hold", 3'd2, 10'd576, 1'b0, 4'd0);

`ifdef HITSTUN_EN
    do_reset();
    pulse_attack();
    repeat (3) tick();
    check_out("pre_hit", 3'd4, 10'd100, 1'b1, 4'd2);
    pulse_hit();
    tick();
    check_out("hitstun0", 3'd3, 10'd100, 1'b0, 4'd0);
    for (int p = 1; p < 12; p++) begin
      if (p == 5) pulse_hit();
      tick();
      check_out($sformatf("hitstun%0d", p), 3'd3, 10'd100, 1'b0, 4'(p));
    end
    tick();
    check_out("hitstun_done", 3'd0, 10'd100, 1'b0, 4'd0);
    tick();
    check_out("hit_discarded", 3'd0, 10'd100, 1'b0, 4'd0);
    pulse_hit();
    tick();
    repeat (3) tick();
    check_out("hitstun_again", 3'd3, 10'd100, 1'b0, 4'd3);
`else
    do_reset();
    pulse_hit();
    tick();
    check_out("hit_ignored", 3'd0, 10'd100, 1'b0, 4'd0);
    pulse_attack();
    repeat (6) tick();
    check_out("mid_attack", 3'd5, 10'd100, 1'b1, 4'd0);
`endif

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1 check_out("async_rst", 3'd0, 10'd100, 1'b0, 4'd0);
    #3 rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
